// File: rtl/barrel_shifter_arbiter.sv
// Round-robin arbiter sharing one combinational barrel shifter between the ALU pipe (A)
// and the address pipe (B), with locked bursts and a one-entry registered result buffer.
module barrel_shifter_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned AMT_W    = 5,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              a_valid_in,
    input  logic              b_valid_in,
    input  logic              a_lock_in,
    input  logic              b_lock_in,
    input  logic [DATA_W-1:0] a_data_in,
    input  logic [DATA_W-1:0] b_data_in,
    input  logic [AMT_W-1:0]  a_amt_in,
    input  logic [AMT_W-1:0]  b_amt_in,
    input  logic [1:0]        a_op_in,
    input  logic [1:0]        b_op_in,
    input  logic              a_cf_in,
    input  logic              b_cf_in,
    output logic              a_ready_out,
    output logic              b_ready_out,
    output logic [DATA_W-1:0] sh_data_out,
    output logic [AMT_W-1:0]  sh_amt_out,
    output logic [1:0]        sh_op_out,
    output logic              sh_cf_out,
    input  logic [DATA_W-1:0] sh_data_in,
    input  logic              sh_cf_in,
    output logic              res_valid_out,
    output logic              res_id_out,
    output logic [DATA_W-1:0] res_data_out,
    output logic              res_cf_out,
    input  logic              res_ready_in,
    output logic              busy_out
);

    localparam int unsigned          CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        ST_ARB,
        ST_LOCK_A,
        ST_LOCK_B
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_lock_cnt;
    logic [CNT_W-1:0]   w_lock_cnt_nxt;
    logic               r_last_grant;   // 0 = A, 1 = B
    logic               r_res_valid;
    logic               r_res_id;
    logic [DATA_W-1:0]  r_res_data;
    logic               r_res_cf;

    logic               w_grant_a;
    logic               w_grant_b;
    logic               w_space;
    logic               w_xfer_a;
    logic               w_xfer_b;
    logic               w_xfer;
    logic               w_xfer_lock;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        unique case (r_state)
            ST_LOCK_A: w_grant_a = 1'b1;
            ST_LOCK_B: w_grant_b = 1'b1;
            default: begin
                if (a_valid_in && b_valid_in) begin
                    w_grant_a = r_last_grant;
                    w_grant_b = !r_last_grant;
                end else begin
                    w_grant_a = a_valid_in;
                    w_grant_b = b_valid_in;
                end
            end
        endcase
    end

    assign w_space     = !r_res_valid || res_ready_in;
    // No accept is signalled while reset is held, so a request cannot be lost to it.
    assign w_xfer_a    = w_grant_a && a_valid_in && w_space && reset_in;
    assign w_xfer_b    = w_grant_b && b_valid_in && w_space && reset_in;
    assign w_xfer      = w_xfer_a || w_xfer_b;
    assign w_xfer_lock = w_xfer_a ? a_lock_in : b_lock_in;

    assign a_ready_out = w_xfer_a;
    assign b_ready_out = w_xfer_b;

    assign sh_data_out = w_grant_b ? b_data_in : a_data_in;
    assign sh_amt_out  = w_grant_b ? b_amt_in  : a_amt_in;
    assign sh_op_out   = w_grant_b ? b_op_in   : a_op_in;
    assign sh_cf_out   = w_grant_b ? b_cf_in   : a_cf_in;

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_xfer) begin
            if (!w_xfer_lock || (LOCK_MAX <= 1) ||
                ((r_state != ST_ARB) && (r_lock_cnt == CNT_LAST))) begin
                w_state_nxt    = ST_ARB;
                w_lock_cnt_nxt = '0;
            end else if (r_state == ST_ARB) begin
                w_state_nxt    = w_xfer_a ? ST_LOCK_A : ST_LOCK_B;
                w_lock_cnt_nxt = CNT_W'(1);
            end else begin
                w_lock_cnt_nxt = r_lock_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state      <= ST_ARB;
            r_lock_cnt   <= '0;
            r_last_grant <= 1'b1;
            r_res_valid  <= 1'b0;
            r_res_id     <= 1'b0;
            r_res_data   <= '0;
            r_res_cf     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_xfer) begin
                r_res_valid  <= 1'b1;
                r_res_id     <= w_xfer_b;
                r_res_data   <= sh_data_in;
                r_res_cf     <= sh_cf_in;
                r_last_grant <= w_xfer_b;
            end else if (res_ready_in) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid_out = r_res_valid;
    assign res_id_out    = r_res_id;
    assign res_data_out  = r_res_data;
    assign res_cf_out    = r_res_cf;
    assign busy_out      = (r_state != ST_ARB);

endmodule

// File: tb/tb_barrel_shifter_arbiter.sv
// Bench for barrel_shifter_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_barrel_shifter_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          reset_in;
    logic          a_valid_in, b_valid_in, a_lock_in, b_lock_in;
    logic [DW-1:0] a_data_in, b_data_in;
    logic [AW-1:0] a_amt_in, b_amt_in;
    logic [1:0]    a_op_in, b_op_in;
    logic          a_cf_in, b_cf_in;
    logic          a_ready_out, b_ready_out;
    logic [DW-1:0] sh_data_out;
    logic [AW-1:0] sh_amt_out;
    logic [1:0]    sh_op_out;
    logic          sh_cf_out;
    logic [DW-1:0] sh_data_in;
    logic          sh_cf_in;
    logic          res_valid_out, res_id_out, res_cf_out, res_ready_in, busy_out;
    logic [DW-1:0] res_data_out;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state: lock owner (-1 none), grants in current burst, last grant, buffer.
    int            m_owner;
    int            m_burst;
    int            m_last;
    bit            m_bv, m_bid, m_bcf;
    logic [DW-1:0] m_bd;

    always #5 clk = ~clk;

    barrel_shifter_arbiter #(.DATA_W(DW), .AMT_W(AW), .LOCK_MAX(LM)) dut (
        .clk_in(clk), .reset_in(reset_in),
        .a_valid_in(a_valid_in), .b_valid_in(b_valid_in),
        .a_lock_in(a_lock_in), .b_lock_in(b_lock_in),
        .a_data_in(a_data_in), .b_data_in(b_data_in),
        .a_amt_in(a_amt_in), .b_amt_in(b_amt_in),
        .a_op_in(a_op_in), .b_op_in(b_op_in),
        .a_cf_in(a_cf_in), .b_cf_in(b_cf_in),
        .a_ready_out(a_ready_out), .b_ready_out(b_ready_out),
        .sh_data_out(sh_data_out), .sh_amt_out(sh_amt_out),
        .sh_op_out(sh_op_out), .sh_cf_out(sh_cf_out),
        .sh_data_in(sh_data_in), .sh_cf_in(sh_cf_in),
        .res_valid_out(res_valid_out), .res_id_out(res_id_out),
        .res_data_out(res_data_out), .res_cf_out(res_cf_out),
        .res_ready_in(res_ready_in), .busy_out(busy_out)
    );

    function automatic logic [DW:0] ref_shift(input logic [DW-1:0] d, input logic [AW-1:0] amt,
                                              input logic [1:0] op, input logic cf);
        int n;
        logic [DW-1:0] r;
        logic c;
        n = int'(amt);
        if (n == 0) return {cf, d};
        case (op)
            2'd0: begin r = d << n; c = d[DW-n]; end
            2'd1: begin r = d >> n; c = d[n-1]; end
            2'd2: begin r = DW'($signed(d) >>> n); c = d[n-1]; end
            default: begin r = (d >> n) | (d << (DW - n)); c = r[DW-1]; end
        endcase
        return {c, r};
    endfunction

    // Stub of the shared shifter, fed from whatever the arbiter presents.
    always_comb {sh_cf_in, sh_data_in} = ref_shift(sh_data_out, sh_amt_out, sh_op_out, sh_cf_out);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_burst = 0; m_last = 1;
        m_bv = 0; m_bid = 0; m_bd = '0; m_bcf = 0;
    endtask

    always @(negedge clk) begin
        bit ga, gb, sp, ea, eb, lk;
        logic [DW:0] r;
        if (!reset_in) begin
            chk("rst_a_ready", a_ready_out, 0);
            chk("rst_b_ready", b_ready_out, 0);
            chk("rst_res_valid", res_valid_out, 0);
            chk("rst_res_id", res_id_out, 0);
            chk("rst_res_data", res_data_out, 0);
            chk("rst_res_cf", res_cf_out, 0);
            chk("rst_busy", busy_out, 0);
            model_reset();
        end else begin
            chk("res_valid", res_valid_out, m_bv);
            chk("res_id", res_id_out, m_bid);
            chk("res_data", res_data_out, m_bd);
            chk("res_cf", res_cf_out, m_bcf);
            chk("busy", busy_out, m_owner >= 0);
            ga = 0; gb = 0;
            if (m_owner == 0) ga = 1;
            else if (m_owner == 1) gb = 1;
            else if (a_valid_in && b_valid_in) begin ga = (m_last == 1); gb = !ga; end
            else begin ga = a_valid_in; gb = b_valid_in; end
            sp = !m_bv || res_ready_in;
            ea = ga && a_valid_in && sp;
            eb = gb && b_valid_in && sp;
            chk("a_ready", a_ready_out, ea);
            chk("b_ready", b_ready_out, eb);
            chk("sh_data", sh_data_out, gb ? b_data_in : a_data_in);
            chk("sh_amt", sh_amt_out, gb ? b_amt_in : a_amt_in);
            chk("sh_op", sh_op_out, gb ? b_op_in : a_op_in);
            chk("sh_cf", sh_cf_out, gb ? b_cf_in : a_cf_in);
            if (ea || eb) begin
                r = ea ? ref_shift(a_data_in, a_amt_in, a_op_in, a_cf_in)
                       : ref_shift(b_data_in, b_amt_in, b_op_in, b_cf_in);
                m_bv = 1; m_bid = eb; m_bd = r[DW-1:0]; m_bcf = r[DW];
                m_last = eb ? 1 : 0;
                lk = ea ? a_lock_in : b_lock_in;
                if (!lk) begin
                    m_owner = -1; m_burst = 0;
                end else begin
                    m_burst++;
                    if (m_burst >= LM) begin m_owner = -1; m_burst = 0; end
                    else m_owner = eb ? 1 : 0;
                end
            end else if (res_ready_in) begin
                m_bv = 0;
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int nb;
        bit ha, hb;
        model_reset();
        reset_in = 0;
        a_valid_in = 1; a_lock_in = 0; a_data_in = 32'h8000_0001; a_amt_in = 5'd1;
        a_op_in = 2'd3; a_cf_in = 0;
        b_valid_in = 0; b_lock_in = 0; b_data_in = '0; b_amt_in = '0; b_op_in = '0; b_cf_in = 0;
        res_ready_in = 1;

        // Reset, first accept and one-cycle result latency.
        repeat (3) to_sample();
        chk("t1_rst_a_ready", a_ready_out, 0);
        @(posedge clk); #1 reset_in = 1;
        to_sample();
        chk("t1_a_ready", a_ready_out, 1);
        to_drive(); a_valid_in = 0;
        to_sample();
        chk("t1_res_valid", res_valid_out, 1);
        chk("t1_res_id", res_id_out, 0);
        chk("t1_res_data", res_data_out, 32'hC000_0000);
        chk("t1_res_cf", res_cf_out, 1);

        // Round-robin alternation, starting with B since A won last.
        for (int i = 0; i < 8; i++) begin
            to_drive();
            a_valid_in = 1; b_valid_in = 1;
            a_data_in = $urandom; b_data_in = $urandom;
            a_amt_in = AW'($urandom); b_amt_in = AW'($urandom);
            a_op_in = 2'($urandom); b_op_in = 2'($urandom);
            to_sample();
            chk("t2_b_ready", b_ready_out, (i % 2) == 0);
            chk("t2_a_ready", a_ready_out, (i % 2) == 1);
            if (i > 0) begin
                chk("t2_res_id", res_id_out, (i % 2) == 1);
                chk("t2_res_valid", res_valid_out, 1);
            end
        end

        // Back-pressure, then drain and accept in the same cycle.
        to_drive();
        res_ready_in = 0; b_valid_in = 0; a_valid_in = 1;
        a_data_in = 32'h0000_00F0; a_amt_in = 5'd4; a_op_in = 2'd1; a_cf_in = 0;
        for (int i = 0; i < 2; i++) begin
            to_sample();
            chk("t3_a_ready_stall", a_ready_out, 0);
            chk("t3_b_ready_stall", b_ready_out, 0);
            chk("t3_res_valid_stall", res_valid_out, 1);
            if (i == 0) to_drive();
        end
        to_drive(); res_ready_in = 1;
        to_sample();
        chk("t3_a_ready", a_ready_out, 1);
        to_drive(); a_valid_in = 0;
        to_sample();
        chk("t3_res_valid", res_valid_out, 1);
        chk("t3_res_data", res_data_out, 32'h0000_000F);
        chk("t3_res_cf", res_cf_out, 0);
        chk("t3_res_id", res_id_out, 0);

        // Locked burst: lock held for 3 B transfers, released on the 4th.
        nb = 0;
        for (int i = 0; i < 5; i++) begin
            to_drive();
            a_valid_in = 1; b_valid_in = 1; a_lock_in = 0; b_lock_in = (nb < 3);
            to_sample();
            chk("t4_b_ready", b_ready_out, i < 4);
            chk("t4_a_ready", a_ready_out, i == 4);
            chk("t4_busy", busy_out, (i >= 1) && (i <= 3));
            if (b_ready_out) nb++;
        end

        // Stuck lock: forced release after LOCK_MAX grants.
        for (int i = 0; i < LM + 1; i++) begin
            to_drive();
            a_valid_in = 1; b_valid_in = 1; a_lock_in = 0; b_lock_in = 1;
            to_sample();
            chk("t5_b_ready", b_ready_out, i < LM);
            chk("t5_a_ready", a_ready_out, i == LM);
            chk("t5_busy", busy_out, (i >= 1) && (i < LM));
        end

        // Leave any B lock, enter LOCK_A, then reset asynchronously mid-burst.
        for (int i = 0; i < 2; i++) begin
            to_drive(); a_valid_in = 0; b_valid_in = 1; b_lock_in = 0;
            to_sample();
        end
        to_drive(); b_valid_in = 0; a_valid_in = 1; a_lock_in = 1;
        to_sample();
        chk("t6_a_ready", a_ready_out, 1);
        to_drive();
        to_sample();
        chk("t6_busy", busy_out, 1);
        chk("t6_res_valid", res_valid_out, 1);
        #2 reset_in = 0;
        #1;
        chk("t6_async_res_valid", res_valid_out, 0);
        chk("t6_async_busy", busy_out, 0);
        to_drive(); a_lock_in = 0; a_valid_in = 1; b_valid_in = 1;
        to_sample();
        to_drive(); reset_in = 1;
        to_sample();
        chk("t6_tie_a_ready", a_ready_out, 1);
        chk("t6_tie_b_ready", b_ready_out, 0);

        // Randomized traffic; held requests keep their fields.
        ha = 0; hb = 0;
        for (int i = 0; i < 800; i++) begin
            to_drive();
            reset_in = ($urandom_range(0, 199) != 0);
            res_ready_in = ($urandom_range(0, 9) < 7);
            if (!ha) begin
                a_valid_in = ($urandom_range(0, 3) != 0);
                a_lock_in = ($urandom_range(0, 3) == 0);
                a_data_in = $urandom; a_amt_in = AW'($urandom);
                a_op_in = 2'($urandom); a_cf_in = 1'($urandom);
            end
            if (!hb) begin
                b_valid_in = ($urandom_range(0, 3) != 0);
                b_lock_in = ($urandom_range(0, 3) == 0);
                b_data_in = $urandom; b_amt_in = AW'($urandom);
                b_op_in = 2'($urandom); b_cf_in = 1'($urandom);
            end
            to_sample();
            ha = a_valid_in && !a_ready_out;
            hb = b_valid_in && !b_ready_out;
        end

        to_drive();
        reset_in = 1;
        to_sample();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
